// File: rtl/sel_scanner_pkg.sv
// Shared definitions for the decoder select scanner: select width, FSM states
// and the modulo-8 advance helper.
package sel_scanner_pkg;

    localparam int SEL_W = 3;

    typedef enum logic {
        HOLD = 1'b0,
        AUTO = 1'b1
    } scan_state_t;

    localparam logic [SEL_W-1:0] SEL_ONE = SEL_W'(1);

    // Natural wrap of the SEL_W-bit sum gives the 7->0 / 0->7 rollover.
    function automatic logic [SEL_W-1:0] sel_advance(input logic [SEL_W-1:0] cur,
                                                     input logic             down);
        return down ? (cur - SEL_ONE) : (cur + SEL_ONE);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, stable-level debouncer and
// a one-cycle press pulse on each accepted 0->1 level change.
module btn_debounce #(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       sync_ff;
    logic [CNT_W-1:0] cnt;
    logic             level;

    // The count only survives while the synchronized input keeps disagreeing
    // with the accepted level; a single agreeing cycle starts it over.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_ff <= '0;
            cnt     <= '0;
            level   <= 1'b0;
            press   <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[0], btn};
            press   <= 1'b0;
            if (sync_ff[1] != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync_ff[1];
                    cnt   <= '0;
                    press <= sync_ff[1];
                end else begin
                    cnt <= cnt + CNT_ONE;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/sel_scanner.sv
// 3-bit select scanner for a 3-to-8 decoder: manual stepping in HOLD,
// prescaled auto-scan in AUTO, debounced step/clear buttons.
module sel_scanner
    import sel_scanner_pkg::*;
#(
    parameter int SCAN_DIV   = 100000,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             auto_en,
    input  logic             dir,
    input  logic             btn_step,
    input  logic             btn_clr,
    output logic [SEL_W-1:0] sel,
    output logic             sel_tick
);

    localparam int PRE_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

    logic [1:0]       auto_sync;
    logic [1:0]       dir_sync;
    logic             step_press;
    logic             clr_press;
    scan_state_t      state;
    scan_state_t      state_next;
    logic [PRE_W-1:0] presc;
    logic [PRE_W-1:0] presc_next;
    logic [SEL_W-1:0] sel_next;
    logic             tick_next;
    logic             advance;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step_deb (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_step),
        .press (step_press)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_clr_deb (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_clr),
        .press (clr_press)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= HOLD;
        end else begin
            state <= state_next;
        end
    end

    // Clear wins over any advance in the same cycle; the prescaler is kept at
    // zero whenever the scanner is not (or is about to stop) auto-scanning.
    always_comb begin
        state_next = auto_sync[1] ? AUTO : HOLD;
        advance    = 1'b0;
        presc_next = '0;
        sel_next   = sel;
        tick_next  = 1'b0;

        case (state)
            HOLD: begin
                advance = step_press;
            end
            AUTO: begin
                advance = (presc == PRE_LAST);
                if (!advance && (state_next == AUTO)) begin
                    presc_next = presc + PRE_ONE;
                end
            end
            default: begin
                advance = 1'b0;
            end
        endcase

        if (clr_press) begin
            sel_next   = '0;
            presc_next = '0;
            tick_next  = 1'b1;
        end else if (advance) begin
            sel_next  = sel_advance(sel, dir_sync[1]);
            tick_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            auto_sync <= '0;
            dir_sync  <= '0;
            presc     <= '0;
            sel       <= '0;
            sel_tick  <= 1'b0;
        end else begin
            auto_sync <= {auto_sync[0], auto_en};
            dir_sync  <= {dir_sync[0], dir};
            presc     <= presc_next;
            sel       <= sel_next;
            sel_tick  <= tick_next;
        end
    end

endmodule
